// File: rtl/memory_stage.sv
// memory_stage: Y86-64 M stage. Accepts an E/M instruction, performs its data-memory access, registers the W result.
// Latency: 1 cycle with no access, 2+N cycles with an access (N = memory wait cycles before ack/err).
// Backpressure: m_busy_o is high in every state but IDLE; inputs are ignored while it is high, and HALT keeps it high until reset.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m_valid_i, m_icode_i, m_stat_i,
//   m_cnd_i, m_valE_i, m_valA_i,
//   m_dstE_i, m_dstM_i              instruction from the E/M register
//   m_busy_o                        upstream stall
//   dmem_req_o/we_o/addr_o/wdata_o  data-memory request, held stable until ack or err
//   dmem_rdata_i/ack_i/err_i        data-memory response
//   w_valid_o, w_icode_o, w_stat_o,
//   w_cnd_o, w_valE_o, w_valM_o,
//   w_dstE_o, w_dstM_o              registered result toward write-back (w_valid_o is a 1-cycle pulse)
//
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, an access whose address[2:0] != 0 issues
// no request and completes with status ADR (which then halts the stage).
module memory_stage #(
  parameter int ADDR_W = 64,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid_i,
  input  logic [3:0]        m_icode_i,
  input  logic [2:0]        m_stat_i,
  input  logic              m_cnd_i,
  input  logic [WORD_W-1:0] m_valE_i,
  input  logic [WORD_W-1:0] m_valA_i,
  input  logic [3:0]        m_dstE_i,
  input  logic [3:0]        m_dstM_i,
  output logic              m_busy_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [WORD_W-1:0] dmem_wdata_o,
  input  logic [WORD_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  input  logic              dmem_err_i,
  output logic              w_valid_o,
  output logic [3:0]        w_icode_o,
  output logic [2:0]        w_stat_o,
  output logic              w_cnd_o,
  output logic [WORD_W-1:0] w_valE_o,
  output logic [WORD_W-1:0] w_valM_o,
  output logic [3:0]        w_dstE_o,
  output logic [3:0]        w_dstM_o
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT, S_HALT} state_t;

  state_t r_state;
  state_t w_next;

  // Fields held across the REQ phase; they become the W result when the access completes.
  logic [3:0]        r_icode;
  logic              r_cnd;
  logic [WORD_W-1:0] r_valE;
  logic [3:0]        r_dstE;
  logic [3:0]        r_dstM;

  logic              w_is_wr;
  logic              w_is_rd;
  logic              w_use_valA;
  logic              w_access;
  logic              w_misalign;
  logic              w_accept;
  logic              w_issue;
  logic              w_done;
  logic [WORD_W-1:0] w_addr_sel;

  // Access class: stores/push/call write at valE, mrmovq reads at valE, popq/ret read at valA.
  always_comb begin
    w_is_wr    = 1'b0;
    w_is_rd    = 1'b0;
    w_use_valA = 1'b0;
    case (m_icode_i)
      4'h4, 4'h8, 4'hA: w_is_wr = 1'b1;
      4'h5:             w_is_rd = 1'b1;
      4'h9, 4'hB: begin
        w_is_rd    = 1'b1;
        w_use_valA = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_access   = w_is_wr | w_is_rd;
  assign w_addr_sel = w_use_valA ? m_valA_i : m_valE_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access && (w_addr_sel[2:0] != 3'b000);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && m_valid_i;
  // A non-AOK incoming status suppresses the access and is passed through unchanged.
  assign w_issue  = w_accept && w_access && (m_stat_i == STAT_AOK) && !w_misalign;
  assign w_done   = (r_state == S_REQ) && (dmem_ack_i || dmem_err_i);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = w_issue ? S_REQ : S_OUT;
      S_REQ:  if (w_done)   w_next = S_OUT;
      S_OUT:  w_next = (w_stat_o != STAT_AOK) ? S_HALT : S_IDLE;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; the request is live for exactly the REQ state, so a reset aborts it at once.
  always_comb begin
    m_busy_o   = (r_state != S_IDLE);
    dmem_req_o = (r_state == S_REQ);
    w_valid_o  = (r_state == S_OUT);
  end

  // Datapath: request fields, held fields, and the W result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icode      <= '0;
      r_cnd        <= 1'b0;
      r_valE       <= '0;
      r_dstE       <= RNONE;
      r_dstM       <= RNONE;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      w_icode_o    <= '0;
      w_stat_o     <= '0;
      w_cnd_o      <= 1'b0;
      w_valE_o     <= '0;
      w_valM_o     <= '0;
      w_dstE_o     <= RNONE;
      w_dstM_o     <= RNONE;
    end else begin
      if (w_issue) begin
        r_icode      <= m_icode_i;
        r_cnd        <= m_cnd_i;
        r_valE       <= m_valE_i;
        r_dstE       <= m_dstE_i;
        r_dstM       <= m_dstM_i;
        dmem_we_o    <= w_is_wr;
        dmem_addr_o  <= w_addr_sel[ADDR_W-1:0];
        dmem_wdata_o <= m_valA_i;
      end else if (w_accept) begin
        // No access: the result is ready on the very next cycle.
        w_icode_o <= m_icode_i;
        w_stat_o  <= ((m_stat_i == STAT_AOK) && w_misalign) ? STAT_ADR : m_stat_i;
        w_cnd_o   <= m_cnd_i;
        w_valE_o  <= m_valE_i;
        w_valM_o  <= '0;
        w_dstE_o  <= m_dstE_i;
        w_dstM_o  <= m_dstM_i;
      end

      if (w_done) begin
        // err wins over ack; only an error-free read returns data.
        w_icode_o <= r_icode;
        w_stat_o  <= dmem_err_i ? STAT_ADR : STAT_AOK;
        w_cnd_o   <= r_cnd;
        w_valE_o  <= r_valE;
        w_valM_o  <= (!dmem_err_i && !dmem_we_o) ? dmem_rdata_i : '0;
        w_dstE_o  <= r_dstE;
        w_dstM_o  <= r_dstM;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized scoreboard bench for memory_stage.
// Latency convention: an instruction of latency L accepted at edge k has w_valid_o high in the cycle ending at edge k+L.
// Memory model answers combinationally: with N wait cycles, ack/err is raised in the (N+1)-th cycle that req is high.
module tb_memory_stage;

  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid_i = 1'b0;
  logic [3:0]  m_icode_i = '0;
  logic [2:0]  m_stat_i = '0;
  logic        m_cnd_i = 1'b0;
  logic [63:0] m_valE_i = '0, m_valA_i = '0;
  logic [3:0]  m_dstE_i = '0, m_dstM_i = '0;
  logic        m_busy_o, dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o;
  logic [63:0] dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0, dmem_err_i = 1'b0;
  logic        w_valid_o, w_cnd_o;
  logic [3:0]  w_icode_o, w_dstE_o, w_dstM_o;
  logic [2:0]  w_stat_o;
  logic [63:0] w_valE_o, w_valM_o;

  memory_stage #(.ADDR_W(64), .WORD_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid_i(m_valid_i), .m_icode_i(m_icode_i), .m_stat_i(m_stat_i), .m_cnd_i(m_cnd_i),
    .m_valE_i(m_valE_i), .m_valA_i(m_valA_i), .m_dstE_i(m_dstE_i), .m_dstM_i(m_dstM_i),
    .m_busy_o(m_busy_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .dmem_err_i(dmem_err_i),
    .w_valid_o(w_valid_o), .w_icode_o(w_icode_o), .w_stat_o(w_stat_o), .w_cnd_o(w_cnd_o),
    .w_valE_o(w_valE_o), .w_valM_o(w_valM_o), .w_dstE_o(w_dstE_o), .w_dstM_o(w_dstM_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    int          due;
  } wexp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          waits;
    logic        err;
  } acc_t;

  wexp_t exp_q[$];
  acc_t  acc_q[$];
  bit    tb_halted = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // 0 none, 1 write at valE, 2 read at valE, 3 read at valA
  function automatic int acc_class(input logic [3:0] ic);
    case (ic)
      4'h4, 4'h8, 4'hA: return 1;
      4'h5:             return 2;
      4'h9, 4'hB:       return 3;
      default:          return 0;
    endcase
  endfunction

  // Monitor + memory responder: the only process that performs comparisons.
  acc_t  cur;
  bit    have = 1'b0;
  int    cnt = 0;
  wexp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 1'b0;
      dmem_ack_i = 1'b0;
      dmem_err_i = 1'b0;
      chk("rst_busy", m_busy_o, 0);
      chk("rst_req", dmem_req_o, 0);
      chk("rst_we", dmem_we_o, 0);
      chk("rst_addr", dmem_addr_o, 0);
      chk("rst_wdata", dmem_wdata_o, 0);
      chk("rst_w_valid", w_valid_o, 0);
      chk("rst_w_icode", w_icode_o, 0);
      chk("rst_w_stat", w_stat_o, 0);
      chk("rst_w_cnd", w_cnd_o, 0);
      chk("rst_w_valE", w_valE_o, 0);
      chk("rst_w_valM", w_valM_o, 0);
      chk("rst_w_dstE", w_dstE_o, 4'hF);
      chk("rst_w_dstM", w_dstM_o, 4'hF);
    end else begin
      if (exp_q.size() != 0 || tb_halted) chk("busy_while_occupied", m_busy_o, 1);
      if (tb_halted) chk("halt_no_req", dmem_req_o, 0);

      if (dmem_req_o) begin
        if (!have) begin
          if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req got addr %h we %0d want no request", dmem_addr_o, dmem_we_o);
            cur.we = dmem_we_o; cur.addr = dmem_addr_o; cur.wdata = dmem_wdata_o;
            cur.rdata = '0; cur.waits = 0; cur.err = 1'b0;
          end else begin
            cur = acc_q.pop_front();
          end
          have = 1'b1;
          cnt = 0;
        end
        chk("req_we", dmem_we_o, cur.we);
        chk("req_addr", dmem_addr_o, cur.addr);
        if (cur.we) chk("req_wdata", dmem_wdata_o, cur.wdata);
        if (cnt == cur.waits) begin
          dmem_ack_i   = 1'b1;
          dmem_err_i   = cur.err;
          dmem_rdata_i = cur.rdata;
        end else begin
          dmem_ack_i   = 1'b0;
          dmem_err_i   = 1'b0;
          dmem_rdata_i = {$urandom, $urandom};
        end
        cnt++;
      end else begin
        have = 1'b0;
        dmem_ack_i = 1'b0;
        dmem_err_i = 1'b0;
        dmem_rdata_i = {$urandom, $urandom};
      end

      if (w_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_w_valid got 1 want 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("w_icode", w_icode_o, e.icode);
          chk("w_stat", w_stat_o, e.stat);
          chk("w_cnd", w_cnd_o, e.cnd);
          chk("w_valE", w_valE_o, e.valE);
          chk("w_valM", w_valM_o, e.valM);
          chk("w_dstE", w_dstE_o, e.dstE);
          chk("w_dstM", w_dstM_o, e.dstM);
          chk("w_latency_cycle", cyc, e.due);
        end
      end
    end
  end

  // Present one instruction; model its expected memory access and W result.
  task automatic issue(input logic [3:0] ic, input logic [2:0] st, input logic cnd,
                       input logic [63:0] vE, input logic [63:0] vA,
                       input logic [3:0] dE, input logic [3:0] dM,
                       input int waits, input logic err, input logic [63:0] rdata,
                       output bit halts);
    int    n, cls, lat;
    bit    acc;
    wexp_t x;
    acc_t  a;
    logic [63:0] addr;
    n = 0;
    while (m_busy_o) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        $display("FAIL issue_wait busy got 1 want 0");
        $fatal(1, "stage never became idle");
      end
    end
    cls  = acc_class(ic);
    addr = (cls == 3) ? vA : vE;
    acc  = 1'b0;
    x.stat = st;
    if (st == AOK && cls != 0) begin
      if (ALIGN && addr[2:0] != 3'b000) x.stat = ADR;
      else begin
        acc = 1'b1;
        x.stat = err ? ADR : AOK;
      end
    end
    x.icode = ic; x.cnd = cnd; x.valE = vE; x.dstE = dE; x.dstM = dM;
    x.valM  = (acc && cls != 1 && !err) ? rdata : 64'd0;
    lat     = acc ? 2 + waits : 1;
    halts   = (x.stat != AOK);
    if (acc) begin
      a.we = (cls == 1); a.addr = addr; a.wdata = vA; a.rdata = rdata;
      a.waits = waits; a.err = err;
      acc_q.push_back(a);
    end
    m_valid_i = 1'b1; m_icode_i = ic; m_stat_i = st; m_cnd_i = cnd;
    m_valE_i = vE; m_valA_i = vA; m_dstE_i = dE; m_dstM_i = dM;
    @(posedge clk); #1;
    x.due = cyc + lat - 1;
    exp_q.push_back(x);
    // Scramble inputs while busy: the stage must work from what it latched.
    m_valid_i = 1'b0;
    m_icode_i = 4'($urandom); m_stat_i = 3'($urandom); m_cnd_i = 1'($urandom);
    m_valE_i = {$urandom, $urandom}; m_valA_i = {$urandom, $urandom};
    m_dstE_i = 4'($urandom); m_dstM_i = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        $display("FAIL drain_timeout pending %0d want 0", exp_q.size());
        $fatal(1, "result never produced");
      end
    end
  endtask

  task automatic do_reset();
    m_valid_i = 1'b0;
    rst_n = 1'b0;
    tb_halted = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Once halted, a valid instruction must be ignored and busy must stay high.
  task automatic hold_halted();
    tb_halted = 1'b1;
    m_valid_i = 1'b1; m_icode_i = 4'h6; m_stat_i = AOK; m_valE_i = 64'h77; m_dstE_i = 4'd1;
    repeat (10) @(posedge clk);
    #1 m_valid_i = 1'b0;
  endtask

  bit h;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(4'h6, AOK, 1'b1, 64'h10, 64'h0, 4'd3, 4'hF, 0, 1'b0, 64'h0, h);
    drain();
    issue(4'h5, AOK, 1'b0, 64'h100, 64'h0, 4'hF, 4'd2, 3, 1'b0, 64'hDEADBEEF, h);
    drain();
    issue(4'hA, AOK, 1'b0, 64'h1F8, 64'h55, 4'd4, 4'hF, 0, 1'b0, 64'h1234, h);
    drain();

    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), AOK, 1'($urandom),
            {$urandom, $urandom} & ~64'h7, {$urandom, $urandom} & ~64'h7,
            4'($urandom), 4'($urandom), $urandom_range(0, 4), 1'b0,
            {$urandom, $urandom}, h);
    end
    drain();

    // POPQ with ack and err together -> ADR, then halt
    issue(4'hB, AOK, 1'b0, 64'h208, 64'h200, 4'd4, 4'd5, 0, 1'b1, 64'hFEED, h);
    drain();
    if (h) hold_halted();
    do_reset();

    // HALT instruction passes HLT status without touching memory
    issue(4'h0, HLT, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 0, 1'b0, 64'h0, h);
    drain();
    if (h) hold_halted();
    do_reset();

    // Reset while an access is outstanding: request drops at once, no result
    issue(4'h5, AOK, 1'b1, 64'h300, 64'h0, 4'hF, 4'd6, 20, 1'b0, 64'hAB, h);
    repeat (4) @(posedge clk);
    #1 do_reset();

    // Misaligned RMMOVQ
    issue(4'h4, AOK, 1'b0, 64'h103, 64'h99, 4'hF, 4'hF, 1, 1'b0, 64'h0, h);
    drain();
    if (h) hold_halted();
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 pipeline M stage, directly downstream of `execute`.
- Consumes the execute result (valE, Cnd) plus the forwarded operands, and performs the data-memory access over a req/ack bus.
- Registers the result toward write-back.
- Raises busy to freeze upstream stages while an access is outstanding.
- Detects memory faults and halts after any non-AOK status.

Parameters:
- ADDR_W, 64, data-memory address width; the low ADDR_W bits of the address operand are driven.
- WORD_W, 64, data word width; matches `D_WORD.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m_valid_i  in  1  instruction presented from E/M register
- m_icode_i  in  4  instruction code (`NIBBLE)
- m_stat_i  in  3  incoming status: AOK=1 HLT=2 ADR=3 INS=4
- m_cnd_i  in  1  Cnd from execute
- m_valE_i  in  WORD_W  execute result
- m_valA_i  in  WORD_W  store data / return address / pop address
- m_dstE_i  in  4  dest reg for valE
- m_dstM_i  in  4  dest reg for valM
- m_busy_o  out  1  stall upstream; inputs ignored while high
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1=write, 0=read
- dmem_addr_o  out  ADDR_W  access address
- dmem_wdata_o  out  WORD_W  write data
- dmem_rdata_i  in  WORD_W  read data, valid with ack
- dmem_ack_i  in  1  access complete
- dmem_err_i  in  1  access faulted (completes access)
- w_valid_o  out  1  one-cycle pulse, W outputs valid
- w_icode_o  out  4  passed icode
- w_stat_o  out  3  final status
- w_cnd_o  out  1  passed Cnd
- w_valE_o  out  WORD_W  passed valE
- w_valM_o  out  WORD_W  loaded data, 0 for non-reads
- w_dstE_o  out  4  passed dstE
- w_dstM_o  out  4  passed dstM

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, except w_dstE_o = w_dstM_o = 4'hF (RNONE).
  - Any in-flight request is dropped.
- States:
  - IDLE: accept.
  - REQ: access outstanding.
  - OUT: present result.
  - HALT: terminal.
- Access classes, decided in IDLE on acceptance:
  - Write at valE:
    - RMMOVQ(4): data valA.
    - PUSHQ(A): data valA.
    - CALL(8): data valA, the return address.
  - Read at valE: MRMOVQ(5).
  - Read at valA: POPQ(B), RET(9).
  - All other icodes: no access.
- IDLE with m_valid_i=1: latch all inputs.
  - Access class and m_stat_i==AOK: drive dmem_req_o=1 with we/addr/wdata next cycle, go to REQ.
  - Otherwise: go to OUT with valM=0.
- REQ:
  - req/we/addr/wdata stay stable until dmem_ack_i or dmem_err_i is sampled high.
  - dmem_err_i=1 (including when ack is also 1): status becomes ADR(3), valM=0.
  - Else, on ack: valM = dmem_rdata_i for reads, 0 for writes.
  - In both cases deassert req on the next edge and go to OUT.
- OUT:
  - Assert w_valid_o for exactly one cycle. w_* registers hold their value until the next OUT.
  - Go to HALT if the final status != AOK, else go to IDLE.
- HALT:
  - m_busy_o=1 permanently; no further requests.
  - Left only by reset.
- m_busy_o = (state != IDLE).
- Latency, acceptance edge to w_valid_o:
  - No access: 1 cycle.
  - Access: 2 + N cycles, where N = wait cycles before ack. An ack in the first REQ cycle gives 2.
- Incoming non-AOK status (HLT/ADR/INS) suppresses the access and is passed through. This leads to HALT.
- m_cnd_i, valE, dstE and dstM pass through unmodified. Cnd-based dstE squash is not done here.
- Address truncation: dmem_addr_o = low ADDR_W bits of the selected operand.
- Reset asserted in REQ: request aborts immediately, and no w_valid_o is produced.

Optional Feature:
- MEM_ALIGN_CHECK_EN
- Defined: in IDLE, an access whose address[2:0] != 0 issues no request. Status becomes ADR, and the block goes to OUT after 1 cycle, then HALT.
- Undefined: no alignment check; misaligned addresses are issued to memory unchanged.

Test Plan:
- Reset check: rst_n low → all W outputs 0, dstE/dstM=F, busy=0. Then OPQ (icode 6, valE=0x10, dstE=3, AOK) → w_valid 1 cycle later, valE=0x10, valM=0, dstE=3.
- MRMOVQ, valE=0x100, ack after 3 wait cycles with rdata=0xDEADBEEF → req/addr 0x100 stable for the whole wait, we=0. Then w_valid with valM=0xDEADBEEF, stat=AOK, latency 5; busy high throughout.
- PUSHQ, valE=0x1F8, valA=0x55, ack in first cycle → we=1, addr 0x1F8, wdata 0x55, latency 2, valM=0.
- POPQ, valA=0x200, with ack and err asserted together → read at 0x200. Then w_stat=ADR, valM=0, block enters HALT. A following valid OPQ is ignored, busy stays 1 until reset.
- HALT instruction (icode 0, stat HLT) → no dmem_req, w_stat=HLT after 1 cycle, then HALT.
- With MEM_ALIGN_CHECK_EN: RMMOVQ to 0x103 → no request, w_stat=ADR. Without it: request to 0x103 is issued.
